// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_ctrl
// Brief    : Run-controlled serial pattern detector with a programmable sample rate
// Revision : 1.0
// ============================================================================
module seq_det_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [15:0]      cfg_div,
    input  logic             w,
    output logic             running,
    output logic             sample_tick,
    output logic             out,
    output logic [CNT_W-1:0] det_count,
    output logic             cfg_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    state_t           r_state;
    logic [7:0]       r_pattern;
    logic [3:0]       r_len;
    logic             r_overlap;
    logic [15:0]      r_div;
    logic [15:0]      r_tick_cnt;
    logic [7:0]       r_shreg;
    logic [3:0]       r_fill;
    logic [CNT_W-1:0] r_det_count;
    logic             r_cfg_err;

    logic             w_cfg_len_ok;
    logic             w_tick;
    logic             w_match;
    logic [7:0]       w_window;
    logic [7:0]       w_mask;

    assign w_cfg_len_ok = (cfg_len != 4'd0) && (cfg_len <= 4'd8);
    assign w_tick       = (r_state == ST_RUN) && (r_tick_cnt == r_div);

    // The incoming bit completes the window, so a match is visible in the tick cycle itself.
    assign w_window = {r_shreg[6:0], w};
    assign w_mask   = 8'hFF >> (4'd8 - r_len);
    assign w_match  = w_tick && (r_fill >= (r_len - 4'd1))
                      && (((w_window ^ r_pattern) & w_mask) == 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= 16'd0;
            r_shreg     <= 8'd0;
            r_fill      <= 4'd0;
            r_det_count <= '0;
            r_cfg_err   <= 1'b0;
            r_pattern   <= 8'b0000_0011;
            r_len       <= 4'd4;
            r_overlap   <= 1'b1;
            r_div       <= 16'd9;
        end else begin
            r_cfg_err <= cfg_we && ((r_state == ST_RUN) || !w_cfg_len_ok);

            if (cfg_we && (r_state == ST_IDLE) && w_cfg_len_ok) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_div     <= cfg_div;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_state     <= ST_RUN;
                        r_tick_cnt  <= 16'd0;
                        r_shreg     <= 8'd0;
                        r_fill      <= 4'd0;
                        r_det_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_tick) begin
                        r_tick_cnt <= 16'd0;
                        r_shreg    <= w_window;
                        if (w_match && !r_overlap) begin
                            r_fill <= 4'd0;
                        end else if (r_fill < r_len) begin
                            r_fill <= r_fill + 4'd1;
                        end
                        if (w_match && (r_det_count != C_CNT_MAX)) begin
                            r_det_count <= r_det_count + CNT_W'(1);
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 16'd1;
                    end
                    // A stop coinciding with a matching tick still records that match above.
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign running     = (r_state == ST_RUN);
    assign sample_tick = w_tick;
    assign out         = w_match;
    assign det_count   = r_det_count;
    assign cfg_err     = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_ctrl
// Brief    : Self-checking bench for seq_det_ctrl against a bit-history model
// Revision : 1.0
// ============================================================================
module tb_seq_det_ctrl;

    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, start, stop, cfg_we, cfg_overlap, w;
    logic [7:0]       cfg_pattern;
    logic [3:0]       cfg_len;
    logic [15:0]      cfg_div;
    logic             running, sample_tick, out, cfg_err;
    logic [CNT_W-1:0] det_count;

    always #5 clk = ~clk;

    seq_det_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_div    (cfg_div),
        .w          (w),
        .running    (running),
        .sample_tick(sample_tick),
        .out        (out),
        .det_count  (det_count),
        .cfg_err    (cfg_err)
    );

    typedef struct packed {
        logic        rst;
        logic        start;
        logic        stop;
        logic        we;
        logic [7:0]  pat;
        logic [3:0]  len;
        logic        ovl;
        logic [15:0] div;
        logic        w;
    } in_t;

    typedef struct {
        in_t  in;
        logic exp_out;
        int   exp_cnt;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the configuration, run flag, cycles since start and received bit history.
    logic [7:0] m_pat;
    int         m_len, m_div, m_phase, m_cnt;
    bit         m_ovl, m_run, m_err;
    bit         m_valid = 1'b0;
    bit         m_hist[$];
    bit         e_tick, e_match;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input bit st, input bit sp, input bit wi);
        in_t v;
        v = '0;
        v.start = st;
        v.stop  = sp;
        v.w     = wi;
        return v;
    endfunction

    function automatic in_t mkc(input bit st, input logic [7:0] p, input logic [3:0] l,
                                input bit o, input logic [15:0] d);
        in_t v;
        v = '0;
        v.we    = 1'b1;
        v.start = st;
        v.pat   = p;
        v.len   = l;
        v.ovl   = o;
        v.div   = d;
        return v;
    endfunction

    function automatic vec_t mv(input in_t i, input bit o, input int c);
        vec_t r;
        r.in      = i;
        r.exp_out = o;
        r.exp_cnt = c;
        return r;
    endfunction

    task automatic pre(input in_t v);
        reset = v.rst; start = v.start; stop = v.stop; cfg_we = v.we;
        cfg_pattern = v.pat; cfg_len = v.len; cfg_overlap = v.ovl; cfg_div = v.div; w = v.w;
        #1;
        e_tick  = m_run && ((m_phase % (m_div + 1)) == m_div);
        e_match = 1'b0;
        if (e_tick && (m_hist.size() >= m_len - 1)) begin
            e_match = (v.w == m_pat[0]);
            for (int k = 1; k < m_len; k++)
                if (m_hist[m_hist.size() - k] != m_pat[k]) e_match = 1'b0;
        end
        if (m_valid) begin
            chk("running", running, m_run);
            chk("sample_tick", sample_tick, e_tick);
            chk("out", out, e_match);
            chk("det_count", det_count, m_cnt);
            chk("cfg_err", cfg_err, m_err);
        end
    endtask

    task automatic post(input in_t v);
        @(posedge clk);
        if (v.rst) begin
            m_valid = 1'b1; m_run = 1'b0; m_phase = 0; m_hist.delete(); m_cnt = 0; m_err = 1'b0;
            m_pat = 8'h03; m_len = 4; m_ovl = 1'b1; m_div = 9;
        end else begin
            m_err = v.we && (m_run || v.len == 0 || v.len > 8);
            if (e_tick) begin
                m_hist.push_back(v.w);
                if (m_hist.size() > 8) void'(m_hist.pop_front());
                if (e_match) begin
                    if (m_cnt < CMAX) m_cnt++;
                    if (!m_ovl) m_hist.delete();
                end
            end
            if (m_run) m_phase++;
            if (v.we && !m_run && v.len != 0 && v.len <= 8) begin
                m_pat = v.pat; m_len = int'(v.len); m_ovl = v.ovl; m_div = int'(v.div);
            end
            if (!m_run) begin
                if (v.start && !v.stop) begin
                    m_run = 1'b1; m_phase = 0; m_hist.delete(); m_cnt = 0;
                end
            end else if (v.stop) begin
                m_run = 1'b0;
            end
        end
        #1;
    endtask

    task automatic apply(input in_t v);
        pre(v);
        post(v);
    endtask

    initial begin
        vec_t     tbl[$];
        in_t      v;
        in_t      r;
        bit [7:0] wb;
        int       n;

        r = '0;
        r.rst = 1'b1;
        apply(r);
        apply(r);

        // Reset state
        pre(mk(0, 0, 0));
        chk("rst_running", running, 1'b0);
        chk("rst_det_count", det_count, 0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        post(mk(0, 0, 0));

        // Default pattern 0011 at div=0; then 101 with and without overlap
        tbl.push_back(mv(mkc(1, 8'h03, 4'd4, 1, 16'd0), 0, 0));
        tbl.push_back(mv(mk(0, 0, 0), 0, 0));
        tbl.push_back(mv(mk(0, 0, 0), 0, 0));
        tbl.push_back(mv(mk(0, 0, 1), 0, 0));
        tbl.push_back(mv(mk(0, 0, 1), 1, 0));
        tbl.push_back(mv(mk(0, 0, 0), 0, 1));
        tbl.push_back(mv(mk(0, 0, 0), 0, 1));
        tbl.push_back(mv(mk(0, 0, 1), 0, 1));
        tbl.push_back(mv(mk(0, 0, 1), 1, 1));
        tbl.push_back(mv(mk(0, 1, 0), 0, 2));
        tbl.push_back(mv(mk(0, 0, 1), 0, 2));
        tbl.push_back(mv(mkc(1, 8'h05, 4'd3, 1, 16'd0), 0, 2));
        tbl.push_back(mv(mk(0, 0, 1), 0, 0));
        tbl.push_back(mv(mk(0, 0, 0), 0, 0));
        tbl.push_back(mv(mk(0, 0, 1), 1, 0));
        tbl.push_back(mv(mk(0, 0, 0), 0, 1));
        tbl.push_back(mv(mk(0, 0, 1), 1, 1));
        tbl.push_back(mv(mk(0, 1, 0), 0, 2));
        tbl.push_back(mv(mkc(1, 8'h05, 4'd3, 0, 16'd0), 0, 2));
        tbl.push_back(mv(mk(0, 0, 1), 0, 0));
        tbl.push_back(mv(mk(0, 0, 0), 0, 0));
        tbl.push_back(mv(mk(0, 0, 1), 1, 0));
        tbl.push_back(mv(mk(0, 0, 0), 0, 1));
        tbl.push_back(mv(mk(0, 0, 1), 0, 1));
        tbl.push_back(mv(mk(0, 1, 0), 0, 1));
        tbl.push_back(mv(mk(0, 0, 0), 0, 1));
        foreach (tbl[i]) begin
            pre(tbl[i].in);
            chk($sformatf("tbl%0d_out", i), out, tbl[i].exp_out);
            chk($sformatf("tbl%0d_cnt", i), det_count, tbl[i].exp_cnt);
            post(tbl[i].in);
        end

        // div=3: ticks every fourth cycle, out never between ticks
        apply(mkc(0, 8'h03, 4'd4, 1, 16'd3));
        apply(mk(1, 0, 0));
        for (int k = 1; k <= 12; k++) begin
            v = mk(0, 0, 1'($urandom_range(0, 1)));
            pre(v);
            chk("div3_tick", sample_tick, (k % 4) == 0);
            if ((k % 4) != 0) chk("div3_no_out", out, 1'b0);
            post(v);
        end
        apply(mk(0, 1, 0));

        // Rejected configuration writes keep the old pattern 0011 / div=3
        apply(mkc(0, 8'hFF, 4'd0, 0, 16'd0));
        pre(mk(0, 0, 0)); chk("err_len0", cfg_err, 1'b1); post(mk(0, 0, 0));
        apply(mkc(0, 8'hFF, 4'd9, 0, 16'd0));
        pre(mk(0, 0, 0)); chk("err_len9", cfg_err, 1'b1); post(mk(0, 0, 0));
        apply(mk(1, 0, 0));
        apply(mkc(0, 8'h05, 4'd3, 0, 16'd0));
        pre(mk(0, 0, 0)); chk("err_in_run", cfg_err, 1'b1); post(mk(0, 0, 0));
        apply(mk(0, 0, 0)); apply(mk(0, 0, 0));
        wb = 8'b0000_0011;
        for (int s = 3; s >= 0; s--)
            for (int c = 0; c < 4; c++) apply(mk(0, 0, wb[s]));
        pre(mk(0, 0, 0)); chk("old_pattern_cnt", det_count, 1); post(mk(0, 0, 0));
        apply(mk(0, 1, 0));

        // stop together with a matching tick
        apply(mkc(1, 8'h01, 4'd1, 1, 16'd0));
        apply(mk(0, 0, 1));
        pre(mk(0, 1, 1)); chk("stop_match_out", out, 1'b1); post(mk(0, 1, 1));
        pre(mk(0, 0, 1));
        chk("stop_match_cnt", det_count, 2);
        chk("stop_match_idle", running, 1'b0);
        post(mk(0, 0, 1));

        // Saturation
        apply(mk(1, 0, 1));
        for (int k = 0; k < 300; k++) apply(mk(0, 0, 1));
        pre(mk(0, 0, 1)); chk("saturate", det_count, CMAX); post(mk(0, 0, 1));
        apply(mk(0, 1, 0));

        // Reset mid-run after two matches, defaults restored
        apply(mkc(1, 8'h03, 4'd4, 1, 16'd0));
        wb = 8'b0011_0011;
        for (int s = 7; s >= 0; s--) apply(mk(0, 0, wb[s]));
        v = mkc(1, 8'hAA, 4'd2, 0, 16'd0);
        v.rst = 1'b1; v.stop = 1'b1; v.w = 1'b1;
        apply(v);
        pre(mk(0, 0, 0));
        chk("midrst_running", running, 1'b0);
        chk("midrst_cnt", det_count, 0);
        post(mk(0, 0, 0));
        apply(mk(1, 1, 0));
        pre(mk(0, 0, 0)); chk("startstop_idle", running, 1'b0); post(mk(0, 0, 0));
        apply(mk(1, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            pre(mk(0, 0, 0));
            chk("default_div_tick", sample_tick, k == 10);
            post(mk(0, 0, 0));
        end
        apply(mk(0, 1, 0));

        // Randomized runs against the model
        for (int run = 0; run < 40; run++) begin
            v = mkc(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 10)),
                    1'($urandom_range(0, 1)), 16'($urandom_range(0, 4)));
            apply(v);
            if (!v.start) apply(mk(1, 0, 0));
            n = $urandom_range(20, 80);
            for (int k = 0; k < n; k++) begin
                v = mk(($urandom_range(0, 19) == 0), 1'b0, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 29) == 0) begin
                    v.we = 1'b1; v.len = 4'($urandom_range(1, 8)); v.pat = 8'($urandom);
                end
                if ($urandom_range(0, 59) == 0) v.rst = 1'b1;
                apply(v);
            end
            apply(mk(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1))));
            apply(mk(0, 0, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
